// File: rtl/overlay_pkg.sv
// rtl/overlay_pkg.sv - shared types, default offsets and width helper for the overlay compositor
package overlay_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REVEAL = 2'd1,
    STEADY = 2'd2
  } ovl_state_t;

  localparam int DEF_SHADOW_DX = 4;
  localparam int DEF_SHADOW_DY = 4;
  localparam int CNT_W         = 8;
  localparam int REV_W         = 4;

  // Layer-index width, never narrower than one bit.
  function automatic int lid_w(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w = w + 1;
    return w;
  endfunction

endpackage

// File: rtl/overlay_prio_enc.sv
// rtl/overlay_prio_enc.sv - lowest-index priority encoder with valid flag
module overlay_prio_enc #(
  parameter int N = 3,
  parameter int W = 2
) (
  input  logic [N-1:0] req_i,
  output logic [W-1:0] idx_o,
  output logic         valid_o
);

  always_comb begin
    idx_o = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req_i[i]) idx_o = W'(i);
    end
  end

  assign valid_o = |req_i;

endmodule

// File: rtl/overlay_compositor.sv
// rtl/overlay_compositor.sv - multi-layer text/shadow overlay with frame-synchronous reveal and blink
module overlay_compositor
  import overlay_pkg::*;
#(
  parameter int NUM_LAYERS    = 3,
  parameter int COORD_W       = 10,
  parameter int SHADOW_DX     = DEF_SHADOW_DX,
  parameter int SHADOW_DY     = DEF_SHADOW_DY,
  parameter int REVEAL_FRAMES = 30,
  parameter int BLINK_FRAMES  = 0,
  localparam int LID_W        = lid_w(NUM_LAYERS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [COORD_W-1:0]    x,
  input  logic [COORD_W-1:0]    y,
  output logic [COORD_W-1:0]    x_shadow,
  output logic [COORD_W-1:0]    y_shadow,
  input  logic [NUM_LAYERS-1:0] main_hit,
  input  logic [NUM_LAYERS-1:0] shadow_hit,
  input  logic [NUM_LAYERS-1:0] layer_en,
  input  logic                  frame_start,
  input  logic                  restart,
  output logic                  text_active,
  output logic                  overlay_active,
  output logic [LID_W-1:0]      layer_id,
  output logic                  reveal_done
);

  localparam logic [REV_W-1:0] NL         = REV_W'(NUM_LAYERS);
  localparam logic [CNT_W-1:0] REV_LAST   = CNT_W'(REVEAL_FRAMES - 1);
  localparam logic [CNT_W-1:0] BLINK_LAST = CNT_W'(BLINK_FRAMES - 1);

  ovl_state_t            state_q, state_d;
  logic [REV_W-1:0]      revealed_q, revealed_d;
  logic [CNT_W-1:0]      frame_cnt_q, frame_cnt_d;
  logic                  blink_off_q, blink_off_d;
  logic [NUM_LAYERS-1:0] en_q;
  logic [NUM_LAYERS-1:0] vis, main_vis, shadow_vis;
  logic [LID_W-1:0]      main_idx, shadow_idx, layer_id_d;
  logic                  main_valid, shadow_valid, text_d, overlay_d;
  logic                  text_q, overlay_q;
  logic [LID_W-1:0]      layer_id_q;

  assign x_shadow = x - COORD_W'(SHADOW_DX);
  assign y_shadow = y - COORD_W'(SHADOW_DY);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      revealed_q  <= '0;
      frame_cnt_q <= '0;
      blink_off_q <= 1'b0;
      en_q        <= '1;
    end else begin
      state_q     <= state_d;
      revealed_q  <= revealed_d;
      frame_cnt_q <= frame_cnt_d;
      blink_off_q <= blink_off_d;
      if (frame_start) en_q <= layer_en;
    end
  end

  // frame_cnt paces reveals in REVEAL and blink half-periods in STEADY.
  always_comb begin
    state_d     = state_q;
    revealed_d  = revealed_q;
    frame_cnt_d = frame_cnt_q;
    blink_off_d = blink_off_q;
    if (restart) begin
      state_d     = IDLE;
      revealed_d  = '0;
      frame_cnt_d = '0;
      blink_off_d = 1'b0;
    end else if (frame_start) begin
      case (state_q)
        IDLE: begin
          revealed_d  = REV_W'(1);
          frame_cnt_d = '0;
          blink_off_d = 1'b0;
          state_d     = (NL == REV_W'(1)) ? STEADY : REVEAL;
        end
        REVEAL: begin
          if (frame_cnt_q == REV_LAST) begin
            frame_cnt_d = '0;
            revealed_d  = revealed_q + REV_W'(1);
            if (revealed_q + REV_W'(1) == NL) state_d = STEADY;
          end else begin
            frame_cnt_d = frame_cnt_q + CNT_W'(1);
          end
        end
        STEADY: begin
          if (BLINK_FRAMES != 0) begin
            if (frame_cnt_q == BLINK_LAST) begin
              frame_cnt_d = '0;
              blink_off_d = ~blink_off_q;
            end else begin
              frame_cnt_d = frame_cnt_q + CNT_W'(1);
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    reveal_done = (state_q == STEADY);
  end

  always_comb begin
    vis = '0;
    for (int i = 0; i < NUM_LAYERS; i++) begin
      vis[i] = en_q[i] && (REV_W'(i) < revealed_q);
    end
  end

  assign main_vis   = main_hit & vis & {NUM_LAYERS{~blink_off_q}};
  assign shadow_vis = shadow_hit & vis;

  overlay_prio_enc #(.N(NUM_LAYERS), .W(LID_W)) u_main_enc (
    .req_i   (main_vis),
    .idx_o   (main_idx),
    .valid_o (main_valid)
  );

  overlay_prio_enc #(.N(NUM_LAYERS), .W(LID_W)) u_shadow_enc (
    .req_i   (shadow_vis),
    .idx_o   (shadow_idx),
    .valid_o (shadow_valid)
  );

  assign text_d     = main_valid;
  assign overlay_d  = main_valid | shadow_valid;
  assign layer_id_d = main_valid ? main_idx : (shadow_valid ? shadow_idx : '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      text_q     <= 1'b0;
      overlay_q  <= 1'b0;
      layer_id_q <= '0;
    end else begin
      text_q     <= text_d;
      overlay_q  <= overlay_d;
      layer_id_q <= layer_id_d;
    end
  end

  assign text_active    = text_q;
  assign overlay_active = overlay_q;
  assign layer_id       = layer_id_q;

endmodule

// File: tb/tb_overlay_compositor.sv
// tb/tb_overlay_compositor.sv - self-checking bench for overlay_compositor
module tb_overlay_compositor;

  localparam int NL = 3;
  localparam int CW = 10;
  localparam int RF = 2;
  localparam int BF = 1;
  localparam int SE = 1 + (NL - 1) * RF;

  logic          clk = 1'b0;
  logic          rst;
  logic [CW-1:0] x, y, x_shadow, y_shadow;
  logic [NL-1:0] main_hit, shadow_hit, layer_en;
  logic          frame_start, restart;
  logic          text_active, overlay_active, reveal_done;
  logic [1:0]    layer_id;

  int            n_chk = 0;
  int            n_fail = 0;
  int            nf = 0;
  logic [NL-1:0] en_m = '1;

  overlay_compositor #(
    .NUM_LAYERS(NL), .COORD_W(CW), .SHADOW_DX(4), .SHADOW_DY(4),
    .REVEAL_FRAMES(RF), .BLINK_FRAMES(BF)
  ) dut (
    .clk(clk), .rst(rst), .x(x), .y(y), .x_shadow(x_shadow), .y_shadow(y_shadow),
    .main_hit(main_hit), .shadow_hit(shadow_hit), .layer_en(layer_en),
    .frame_start(frame_start), .restart(restart),
    .text_active(text_active), .overlay_active(overlay_active),
    .layer_id(layer_id), .reveal_done(reveal_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int revealed_m();
    int r;
    if (nf == 0) return 0;
    r = 1 + (nf - 1) / RF;
    return (r > NL) ? NL : r;
  endfunction

  function automatic bit blink_m();
    if (BF == 0 || nf < SE) return 1'b0;
    return (((nf - SE) / BF) % 2) == 1;
  endfunction

  task automatic expect_pixel(input logic [NL-1:0] m, input logic [NL-1:0] s,
                              output int et, output int eo, output int el);
    int  rv;
    bit  bo;
    bit  found;
    rv = revealed_m();
    bo = blink_m();
    et = 0; eo = 0; el = 0; found = 0;
    for (int i = 0; i < NL; i++) begin
      if (!found && m[i] && en_m[i] && i < rv && !bo) begin
        et = 1; el = i; found = 1;
      end
    end
    for (int i = 0; i < NL; i++) begin
      if (!found && s[i] && en_m[i] && i < rv) begin
        el = i; found = 1;
      end
    end
    eo = found ? 1 : 0;
  endtask

  task automatic step(input logic [NL-1:0] m, input logic [NL-1:0] s,
                      input logic [NL-1:0] e, input logic f, input logic r);
    int et, eo, el;
    @(negedge clk);
    main_hit = m; shadow_hit = s; layer_en = e; frame_start = f; restart = r;
    x = 10'($urandom); y = 10'($urandom);
    #1;
    check("x_shadow", x_shadow, (int'(x) + 1024 - 4) % 1024);
    check("y_shadow", y_shadow, (int'(y) + 1024 - 4) % 1024);
    expect_pixel(m, s, et, eo, el);
    @(posedge clk);
    #1;
    if (r) nf = 0;
    else if (f) nf++;
    if (f) en_m = e;
    check("text_active", text_active, et);
    check("overlay_active", overlay_active, eo);
    check("layer_id", layer_id, el);
    check("reveal_done", reveal_done, (nf >= SE) ? 1 : 0);
  endtask

  initial begin
    rst = 1'b1;
    x = '0; y = '0; main_hit = '0; shadow_hit = '0; layer_en = '1;
    frame_start = 1'b0; restart = 1'b0;
    #7;
    check("rst_text", text_active, 0);
    check("rst_overlay", overlay_active, 0);
    check("rst_lid", layer_id, 0);
    check("rst_done", reveal_done, 0);
    @(negedge clk);
    rst = 1'b0;

    step(3'b001, 3'b000, 3'b111, 1'b0, 1'b0);
    check("idle_hidden_text", text_active, 0);
    step(3'b001, 3'b001, 3'b111, 1'b0, 1'b0);
    check("idle_hidden_ovl", overlay_active, 0);

    for (int k = 1; k <= 5; k++) begin
      step(3'b111, 3'b000, 3'b111, 1'b1, 1'b0);
      check("reveal_done_step", reveal_done, (k == 5) ? 1 : 0);
      step(3'b111, 3'b000, 3'b111, 1'b0, 1'b0);
      check("reveal_lid0", layer_id, 0);
      check("reveal_text", text_active, 1);
    end

    step(3'b000, 3'b100, 3'b111, 1'b0, 1'b0);
    check("shadow_only_ovl", overlay_active, 1);
    check("shadow_only_text", text_active, 0);
    check("shadow_only_lid", layer_id, 2);

    for (int k = 1; k <= 4; k++) begin
      step(3'b010, 3'b010, 3'b111, 1'b1, 1'b0);
      step(3'b010, 3'b010, 3'b111, 1'b0, 1'b0);
      check("blink_text", text_active, (k % 2 == 0) ? 1 : 0);
      check("blink_ovl", overlay_active, 1);
      check("blink_lid", layer_id, 1);
    end

    step(3'b000, 3'b000, 3'b101, 1'b1, 1'b0);
    step(3'b010, 3'b010, 3'b111, 1'b0, 1'b0);
    check("mask_layer1_ovl", overlay_active, 0);

    step(3'b111, 3'b111, 3'b111, 1'b1, 1'b1);
    check("restart_collision_done", reveal_done, 0);
    step(3'b111, 3'b111, 3'b111, 1'b0, 1'b0);
    check("restart_idle_ovl", overlay_active, 0);
    step(3'b000, 3'b000, 3'b111, 1'b1, 1'b0);
    step(3'b001, 3'b000, 3'b111, 1'b0, 1'b0);
    check("restart_reveal1_text", text_active, 1);

    @(negedge clk);
    x = 10'd2; y = 10'd0;
    #1;
    check("wrap_x", x_shadow, 1022);
    check("wrap_y", y_shadow, 1020);

    for (int n = 0; n < 400; n++) begin
      logic [NL-1:0] e;
      e = ($urandom_range(0, 3) == 0) ? NL'($urandom) : '1;
      step(NL'($urandom), NL'($urandom), e,
           $urandom_range(0, 5) == 0, $urandom_range(0, 79) == 0);
      if (n == 200) begin
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("async_rst_text", text_active, 0);
        check("async_rst_ovl", overlay_active, 0);
        check("async_rst_done", reveal_done, 0);
        nf = 0;
        en_m = '1;
        @(negedge clk);
        rst = 1'b0;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
